// File: rtl/thermo_sort_seq_if.sv
// Handshake bundle for the thermometer sorter: word in, sorted word and count out.
// master = producer/consumer side, slave = the sorter itself.
interface thermo_sort_seq_if #(
  parameter int W  = 1024,
  parameter int CW = $clog2(W + 1)
);
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  data_in;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  data_out;
  logic [CW-1:0] ones_cnt;
  logic          busy;

  modport master (
    output in_valid, data_in, out_ready,
    input  in_ready, out_valid, data_out, ones_cnt, busy
  );

  modport slave (
    input  in_valid, data_in, out_ready,
    output in_ready, out_valid, data_out, ones_cnt, busy
  );
endinterface

// File: rtl/thermo_sort_seq.sv
// Sequential ones-compactor: odd-even transposition over a W-bit word, one phase
// per clock, with a popcount captured at load and valid/ready on both sides.
module thermo_sort_seq #(
  parameter int SAMPLES    = 128,
  parameter int OSF        = 8,
  parameter int ONES_LSB   = 1,
  parameter int EARLY_EXIT = 1
) (
  input logic              clk,
  input logic              rst_n,
  thermo_sort_seq_if.slave bus
);
  localparam int W  = SAMPLES * OSF;
  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_PHASE = CW'(W);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_reg, state_next;
  logic [W-1:0]  work_reg, work_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [CW-1:0] phase_reg, phase_next;
  logic          noswap_reg, noswap_next;

  logic [W-2:0]  pair_swap;
  logic [W-1:0]  toggle;
  logic          any_swap;

  function automatic logic [CW-1:0] popcount(input logic [W-1:0] v);
    logic [CW-1:0] c;
    c = '0;
    for (int i = 0; i < W; i++) begin
      c = c + CW'(v[i]);
    end
    return c;
  endfunction

  // Even phases pair (0,1),(2,3)...; odd phases pair (1,2),(3,4)...
  generate
    for (genvar gi = 0; gi < W - 1; gi++) begin : g_pair
      logic active;
      if ((gi % 2) == 0) begin : g_even
        assign active = ~phase_reg[0];
      end else begin : g_odd
        assign active = phase_reg[0];
      end
      if (ONES_LSB != 0) begin : g_lsb
        assign pair_swap[gi] = active & ~work_reg[gi] & work_reg[gi+1];
      end else begin : g_msb
        assign pair_swap[gi] = active & work_reg[gi] & ~work_reg[gi+1];
      end
    end
  endgenerate

  // A swapping pair always holds differing bits, so a swap is just a toggle of both.
  assign toggle   = {1'b0, pair_swap} | {pair_swap, 1'b0};
  assign any_swap = |pair_swap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= IDLE;
      work_reg   <= '0;
      cnt_reg    <= '0;
      phase_reg  <= '0;
      noswap_reg <= 1'b0;
    end else begin
      state_reg  <= state_next;
      work_reg   <= work_next;
      cnt_reg    <= cnt_next;
      phase_reg  <= phase_next;
      noswap_reg <= noswap_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    work_next   = work_reg;
    cnt_next    = cnt_reg;
    phase_next  = phase_reg;
    noswap_next = noswap_reg;
    case (state_reg)
      IDLE: begin
        if (bus.in_valid) begin
          work_next   = bus.data_in;
          cnt_next    = popcount(bus.data_in);
          phase_next  = '0;
          noswap_next = 1'b0;
          state_next  = SORT;
        end
      end
      SORT: begin
        work_next   = work_reg ^ toggle;
        phase_next  = phase_reg + CW'(1);
        noswap_next = ~any_swap;
        // Two consecutive quiet phases (one even, one odd) prove the word is sorted.
        if ((phase_next == LAST_PHASE) ||
            ((EARLY_EXIT != 0) && (phase_reg != '0) && noswap_reg && !any_swap)) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign bus.in_ready  = (state_reg == IDLE);
  assign bus.busy      = (state_reg == SORT);
  assign bus.out_valid = (state_reg == DONE);
  assign bus.data_out  = work_reg;
  assign bus.ones_cnt  = cnt_reg;
endmodule

// File: tb/tb_thermo_sort_seq.sv
// Self-checking bench: three W=8 configurations plus the default W=1024 sorter,
// compared against a popcount/thermometer model of the expected result.
module tb_thermo_sort_seq;
  localparam int WB = 1024;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  thermo_sort_seq_if #(.W(8))  bus_a ();
  thermo_sort_seq_if #(.W(8))  bus_b ();
  thermo_sort_seq_if #(.W(8))  bus_c ();
  thermo_sort_seq_if #(.W(WB)) bus_d ();

  thermo_sort_seq #(.SAMPLES(4), .OSF(2), .ONES_LSB(1), .EARLY_EXIT(1))
    u_a (.clk(clk), .rst_n(rst_n), .bus(bus_a));
  thermo_sort_seq #(.SAMPLES(4), .OSF(2), .ONES_LSB(1), .EARLY_EXIT(0))
    u_b (.clk(clk), .rst_n(rst_n), .bus(bus_b));
  thermo_sort_seq #(.SAMPLES(4), .OSF(2), .ONES_LSB(0), .EARLY_EXIT(1))
    u_c (.clk(clk), .rst_n(rst_n), .bus(bus_c));
  thermo_sort_seq #(.SAMPLES(128), .OSF(8), .ONES_LSB(1), .EARLY_EXIT(1))
    u_d (.clk(clk), .rst_n(rst_n), .bus(bus_d));

  // sel chooses which 8-bit sorter the shared driver talks to: 0=A, 1=B, 2=C
  int         sel        = 0;
  logic       drv_valid  = 1'b0;
  logic       drv_oready = 1'b0;
  logic [7:0] drv_data   = '0;

  assign bus_a.in_valid  = drv_valid && (sel == 0);
  assign bus_b.in_valid  = drv_valid && (sel == 1);
  assign bus_c.in_valid  = drv_valid && (sel == 2);
  assign bus_a.out_ready = drv_oready && (sel == 0);
  assign bus_b.out_ready = drv_oready && (sel == 1);
  assign bus_c.out_ready = drv_oready && (sel == 2);
  assign bus_a.data_in   = drv_data;
  assign bus_b.data_in   = drv_data;
  assign bus_c.data_in   = drv_data;

  logic       mo_in_ready, mo_out_valid, mo_busy;
  logic [7:0] mo_data;
  logic [3:0] mo_cnt;

  always_comb begin
    mo_in_ready  = bus_c.in_ready;
    mo_out_valid = bus_c.out_valid;
    mo_busy      = bus_c.busy;
    mo_data      = bus_c.data_out;
    mo_cnt       = bus_c.ones_cnt;
    if (sel == 0) begin
      mo_in_ready  = bus_a.in_ready;
      mo_out_valid = bus_a.out_valid;
      mo_busy      = bus_a.busy;
      mo_data      = bus_a.data_out;
      mo_cnt       = bus_a.ones_cnt;
    end else if (sel == 1) begin
      mo_in_ready  = bus_b.in_ready;
      mo_out_valid = bus_b.out_valid;
      mo_busy      = bus_b.busy;
      mo_data      = bus_b.data_out;
      mo_cnt       = bus_b.ones_cnt;
    end
  end

  task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic int popc(input logic [1023:0] v, input int w);
    int c = 0;
    for (int i = 0; i < w; i++) begin
      if (v[i]) c++;
    end
    return c;
  endfunction

  function automatic logic [1023:0] thermo(input int c, input int w, input bit lsb);
    logic [1023:0] r = '0;
    for (int i = 0; i < c; i++) begin
      if (lsb) r[i] = 1'b1;
      else     r[w-1-i] = 1'b1;
    end
    return r;
  endfunction

  function automatic logic [1023:0] rand_word(input int mode);
    logic [1023:0] r = '0;
    logic [31:0]   a, b;
    for (int i = 0; i < 32; i++) begin
      a = $urandom;
      b = $urandom;
      case (mode)
        0:       r[i*32 +: 32] = a;
        1:       r[i*32 +: 32] = a & b;
        2:       r[i*32 +: 32] = a | b;
        3:       r[i*32 +: 32] = (i < 4) ? a : 32'h0;
        default: r[i*32 +: 32] = (i >= 28) ? a : 32'h0;
      endcase
    end
    return r;
  endfunction

  task automatic xfer8(input logic [7:0] din, input int hold, output int lat);
    logic [1023:0] e;
    int  c;
    bit  lsb, ee;
    lsb = (sel != 2);
    ee  = (sel != 1);
    c   = popc({1016'b0, din}, 8);
    e   = thermo(c, 8, lsb);
    check("in_ready_idle", mo_in_ready, 1'b1);
    drv_data  = din;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid  = 1'b0;
    drv_oready = 1'b1;   // out_ready during SORT must be ignored
    check("busy_sort", mo_busy, 1'b1);
    lat = 0;
    while (!mo_out_valid && lat < 12) begin
      @(posedge clk); #1;
      drv_oready = 1'b0;
      lat++;
    end
    check("out_valid", mo_out_valid, 1'b1);
    check("data_out", mo_data, e[7:0]);
    check("ones_cnt", mo_cnt, c);
    if (ee) check("lat_range", (lat >= 2 && lat <= 8), 1'b1);
    else    check("lat_fixed", lat, 8);
    for (int i = 0; i < hold; i++) begin
      drv_valid = 1'b1;
      drv_data  = ~din;
      @(posedge clk); #1;
      check("hold_valid", mo_out_valid, 1'b1);
      check("hold_data", mo_data, e[7:0]);
      check("hold_cnt", mo_cnt, c);
      check("hold_in_ready", mo_in_ready, 1'b0);
    end
    drv_valid  = 1'b0;
    drv_oready = 1'b1;
    @(posedge clk); #1;
    drv_oready = 1'b0;
    check("valid_fall", mo_out_valid, 1'b0);
    check("busy_idle", mo_busy, 1'b0);
    $display("xfer sel=%0d din=%h dout=%h cnt=%0d lat=%0d", sel, din, mo_data, c, lat);
  endtask

  task automatic xfer_big(input logic [1023:0] din, output int lat);
    logic [1023:0] e;
    int c;
    c = popc(din, WB);
    e = thermo(c, WB, 1'b1);
    check("big_in_ready", bus_d.in_ready, 1'b1);
    bus_d.data_in  = din;
    bus_d.in_valid = 1'b1;
    @(posedge clk); #1;
    bus_d.in_valid = 1'b0;
    check("big_busy", bus_d.busy, 1'b1);
    lat = 0;
    while (!bus_d.out_valid && lat < WB + 4) begin
      @(posedge clk); #1;
      lat++;
    end
    check("big_out_valid", bus_d.out_valid, 1'b1);
    check("big_data_lo", bus_d.data_out[511:0], e[511:0]);
    check("big_data_hi", bus_d.data_out[1023:512], e[1023:512]);
    check("big_cnt", bus_d.ones_cnt, c);
    check("big_lat_range", (lat >= 2 && lat <= WB), 1'b1);
    bus_d.out_ready = 1'b1;
    @(posedge clk); #1;
    bus_d.out_ready = 1'b0;
    check("big_valid_fall", bus_d.out_valid, 1'b0);
    $display("big cnt=%0d lat=%0d", c, lat);
  endtask

  initial begin
    int  lat;
    bit  seen;
    bus_d.in_valid  = 1'b0;
    bus_d.out_ready = 1'b0;
    bus_d.data_in   = '0;

    #3;
    check("rst_valid_a", bus_a.out_valid, 1'b0);
    check("rst_ready_a", bus_a.in_ready, 1'b1);
    check("rst_busy_a", bus_a.busy, 1'b0);
    check("rst_data_a", bus_a.data_out, 8'h00);
    check("rst_cnt_a", bus_a.ones_cnt, 4'd0);
    check("rst_valid_d", bus_d.out_valid, 1'b0);
    check("rst_cnt_d", bus_d.ones_cnt, 11'd0);
    #20 rst_n = 1'b1;
    @(posedge clk); #1;

    sel = 0;
    xfer8(8'b1010_0100, 0, lat);
    xfer8(8'h00, 0, lat);
    check("lat_zeros", lat, 2);
    xfer8(8'hFF, 0, lat);
    check("lat_ones", lat, 2);

    sel = 1;
    xfer8(8'h80, 0, lat);
    sel = 2;
    xfer8(8'h01, 0, lat);

    // back-pressure, then the next word straight after out_valid falls
    sel = 0;
    xfer8(8'h5A, 5, lat);
    xfer8(8'h3C, 0, lat);

    // asynchronous reset during phase 3 of a fixed-latency sort
    sel = 1;
    check("rst_in_ready", mo_in_ready, 1'b1);
    drv_data  = 8'h80;
    drv_valid = 1'b1;
    @(posedge clk); #1;
    drv_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    check("pre_rst_busy", mo_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", mo_out_valid, 1'b0);
    check("arst_data", mo_data, 8'h00);
    check("arst_cnt", mo_cnt, 4'd0);
    check("arst_in_ready", mo_in_ready, 1'b1);
    check("arst_busy", mo_busy, 1'b0);
    #2 rst_n = 1'b1;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk); #1;
      if (mo_out_valid) seen = 1'b1;
    end
    check("no_stale_result", seen, 1'b0);

    for (int s = 0; s < 3; s++) begin
      sel = s;
      for (int n = 0; n < 60; n++) begin
        xfer8(8'($urandom), 0, lat);
      end
    end

    xfer_big('0, lat);
    check("big_lat_zeros", lat, 2);
    xfer_big('1, lat);
    check("big_lat_ones", lat, 2);
    xfer_big({1'b1, 1023'b0}, lat);
    for (int n = 0; n < 25; n++) begin
      xfer_big(rand_word(n % 5), lat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running exp=finished");
    $fatal(1, "watchdog expired");
  end
endmodule
